kbd_fifo_controller: RTL and testbench

- Next-generation keyboard interface: takes bytes from the serial receiver and decodes PS/2 set-2 prefixes (0xE0 extended, 0xF0 break).
- Queues decoded key events in a parametrised FIFO and presents them to the interrupt controller one at a time over the IRQ/IACK/IEND handshake.
- Sits between the serial receiver and the interrupt controller. Exposes the current key and flags as a register to the CPU bus.

---
 rtl/kbd_fifo_controller.sv | 209 ++++++++++++++++++++
 tb/tb_kbd_fifo_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_fifo_controller.sv
// kbd_fifo_controller
// PS/2 set-2 keyboard front end. Bytes from the serial receiver are
// edge-qualified, then a decoder folds 0xE0 (extended) and 0xF0 (break)
// prefixes into flags. Each complete key event {ext, brk, code} is queued in
// a FIFO and handed to the interrupt controller one at a time over the
// IRQ/IACK/IEND handshake. The event in service is held in KEY_BUFFER and
// KEY_FLAGS for the CPU.
//
// Build option: define KBD_BREAK_FILTER_EN to discard break events before
// they reach the FIFO (make events only; KEY_FLAGS[0] then reads 0).
module kbd_fifo_controller #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  output logic [DATA_W-1:0] KEY_BUFFER,
  output logic [1:0]        KEY_FLAGS,
  output logic              INTC_IRQ,
  input  logic              INTC_IACK,
  input  logic              INTC_IEND,
  output logic [ADDR_W:0]   FIFO_COUNT,
  output logic              OVERFLOW,
  input  logic              OVF_CLR
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int ENTRY_W = DATA_W + 2;

  localparam logic [DATA_W-1:0] CODE_EXT = DATA_W'(8'hE0);
  localparam logic [DATA_W-1:0] CODE_BRK = DATA_W'(8'hF0);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    D_IDLE,
    D_PREFIX
  } dec_state_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_REQ,
    I_SERV
  } irq_state_t;

  // Receiver edge detection
  logic rx_valid_d_reg;
  logic rx_accept;

  // Prefix decoder
  dec_state_t dec_state_reg, dec_state_next;
  logic       ext_reg, ext_next;
  logic       brk_reg, brk_next;
  logic       push_req;
  logic       push_valid;
  logic [ENTRY_W-1:0] push_entry;

  // Event FIFO
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr_reg;
  logic [ADDR_W-1:0]  rd_ptr_reg;
  logic [ADDR_W:0]    count_reg, count_next;
  logic               full;
  logic               wr_en;
  logic               pop;
  logic               drop;

  // Interrupt handshake and CPU-visible state
  irq_state_t         irq_state_reg, irq_state_next;
  logic               irq_next;
  logic [DATA_W-1:0]  key_buffer_reg;
  logic [1:0]         key_flags_reg;
  logic               overflow_reg;

  // A held-high RX_VALID is one byte: accept only on its rising edge.
  always_ff @(posedge CLK) begin
    if (RESET) rx_valid_d_reg <= 1'b0;
    else       rx_valid_d_reg <= RX_VALID;
  end

  assign rx_accept = RX_VALID & ~rx_valid_d_reg;

  // Decoder state and pending prefix flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dec_state_reg <= D_IDLE;
      ext_reg       <= 1'b0;
      brk_reg       <= 1'b0;
    end else begin
      dec_state_reg <= dec_state_next;
      ext_reg       <= ext_next;
      brk_reg       <= brk_next;
    end
  end

  // Prefixes only set flags (idempotently); any other byte completes an event.
  always_comb begin
    dec_state_next = dec_state_reg;
    ext_next       = ext_reg;
    brk_next       = brk_reg;
    push_req       = 1'b0;
    push_entry     = {ext_reg, brk_reg, RX_DATA};
    if (rx_accept) begin
      if (RX_DATA == CODE_EXT) begin
        ext_next       = 1'b1;
        dec_state_next = D_PREFIX;
      end else if (RX_DATA == CODE_BRK) begin
        brk_next       = 1'b1;
        dec_state_next = D_PREFIX;
      end else begin
        push_req       = 1'b1;
        ext_next       = 1'b0;
        brk_next       = 1'b0;
        dec_state_next = D_IDLE;
      end
    end
  end

`ifdef KBD_BREAK_FILTER_EN
  // Break events vanish here, so they never occupy or overflow the FIFO.
  assign push_valid = push_req & ~brk_reg;
`else
  assign push_valid = push_req;
`endif

  // A pop frees a slot in the same cycle, so a push at full still succeeds.
  assign pop   = (irq_state_reg == I_REQ) & INTC_IACK;
  assign full  = (count_reg == COUNT_FULL);
  assign wr_en = push_valid & (~full | pop);
  assign drop  = push_valid & full & ~pop;

  // Occupancy follows the net effect of this cycle's push and pop.
  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage write port; contents are don't-care until counted.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_reg] <= push_entry;
  end

  // Pointers wrap naturally at DEPTH; reset empties the queue.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      count_reg <= count_next;
    end
  end

  // Registered read of the FIFO head; the event is held until the next IACK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      key_buffer_reg <= '0;
      key_flags_reg  <= '0;
    end else if (pop) begin
      {key_flags_reg, key_buffer_reg} <= mem[rd_ptr_reg];
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK) begin
    if (RESET)        overflow_reg <= 1'b0;
    else if (drop)    overflow_reg <= 1'b1;
    else if (OVF_CLR) overflow_reg <= 1'b0;
  end

  // Interrupt handshake state register.
  always_ff @(posedge CLK) begin
    if (RESET) irq_state_reg <= I_IDLE;
    else       irq_state_reg <= irq_state_next;
  end

  // Request while events are queued; IACK pops, IEND ends service.
  always_comb begin
    irq_state_next = irq_state_reg;
    irq_next       = 1'b0;
    case (irq_state_reg)
      I_IDLE: begin
        if (count_reg != '0) irq_state_next = I_REQ;
      end
      I_REQ: begin
        irq_next = 1'b1;
        if (INTC_IACK) irq_state_next = I_SERV;
      end
      I_SERV: begin
        if (INTC_IEND) irq_state_next = I_IDLE;
      end
      default: irq_state_next = I_IDLE;
    endcase
  end

  assign INTC_IRQ   = irq_next;
  assign KEY_BUFFER = key_buffer_reg;
  assign KEY_FLAGS  = key_flags_reg;
  assign FIFO_COUNT = count_reg;
  assign OVERFLOW   = overflow_reg;

endmodule

// File: tb/tb_kbd_fifo_controller.sv
// tb_kbd_fifo_controller
// Directed bench for kbd_fifo_controller. Expected key events are queued
// when the completing byte is driven and compared when IACK delivers them.
// Honours KBD_BREAK_FILTER_EN when deciding which events are expected.
module tb_kbd_fifo_controller;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] RX_DATA = '0;
  logic       RX_VALID = 1'b0;
  logic [7:0] KEY_BUFFER;
  logic [1:0] KEY_FLAGS;
  logic       INTC_IRQ;
  logic       INTC_IACK = 1'b0;
  logic       INTC_IEND = 1'b0;
  logic [3:0] FIFO_COUNT;
  logic       OVERFLOW;
  logic       OVF_CLR = 1'b0;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [9:0] sb_q[$];

  kbd_fifo_controller #(.ADDR_W(3), .DATA_W(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .KEY_BUFFER (KEY_BUFFER),
    .KEY_FLAGS  (KEY_FLAGS),
    .INTC_IRQ   (INTC_IRQ),
    .INTC_IACK  (INTC_IACK),
    .INTC_IEND  (INTC_IEND),
    .FIFO_COUNT (FIFO_COUNT),
    .OVERFLOW   (OVERFLOW),
    .OVF_CLR    (OVF_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record the event a non-prefix byte should produce, given pending flags.
  task automatic expect_event(input logic ext, input logic brk, input logic [7:0] code);
`ifdef KBD_BREAK_FILTER_EN
    if (!brk) sb_q.push_back({ext, brk, code});
`else
    sb_q.push_back({ext, brk, code});
`endif
  endtask

  // One byte: RX_VALID high for one cycle, then low for one cycle.
  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    tick();
  endtask

  // Full IRQ/IACK/IEND round, checking the delivered event.
  task automatic serve(input string tag);
    logic [9:0] exp;
    for (int i = 0; i < 30 && INTC_IRQ !== 1'b1; i++) tick();
    chk({tag, "_irq"}, INTC_IRQ, 1);
    INTC_IACK = 1'b1;
    tick();
    INTC_IACK = 1'b0;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
    chk({tag, "_key"}, KEY_BUFFER, exp[7:0]);
    chk({tag, "_flags"}, KEY_FLAGS, exp[9:8]);
    INTC_IEND = 1'b1;
    tick();
    INTC_IEND = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp;
    logic       irq_seen;

    // Reset state
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_key", KEY_BUFFER, 0);
    chk("rst_flags", KEY_FLAGS, 0);
    chk("rst_irq", INTC_IRQ, 0);
    chk("rst_count", FIFO_COUNT, 0);
    chk("rst_ovf", OVERFLOW, 0);
    tick();

    // Single byte with exact push and IRQ latency
    RX_DATA  = 8'h1C;
    RX_VALID = 1'b1;
    expect_event(1'b0, 1'b0, 8'h1C);
    tick();
    chk("single_count_n1", FIFO_COUNT, 1);
    chk("single_irq_n1", INTC_IRQ, 0);
    RX_VALID = 1'b0;
    tick();
    chk("single_irq_n2", INTC_IRQ, 1);
    INTC_IACK = 1'b1;
    tick();
    INTC_IACK = 1'b0;
    exp = sb_q.pop_front();
    chk("single_key", KEY_BUFFER, exp[7:0]);
    chk("single_flags", KEY_FLAGS, exp[9:8]);
    chk("single_count_pop", FIFO_COUNT, 0);
    INTC_IEND = 1'b1;
    tick();
    INTC_IEND = 1'b0;
    tick();
    tick();
    chk("single_irq_after_iend", INTC_IRQ, 0);

    // Prefixes E0 F0 74
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    expect_event(1'b1, 1'b1, 8'h74);
    chk("prefix_count", FIFO_COUNT, sb_q.size());
    if (sb_q.size() != 0) begin
      serve("prefix");
    end else begin
      irq_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        irq_seen |= INTC_IRQ;
        tick();
      end
      chk("prefix_filtered_irq", irq_seen, 0);
    end

    // Level held high for 10 cycles counts once
    RX_DATA  = 8'h29;
    RX_VALID = 1'b1;
    expect_event(1'b0, 1'b0, 8'h29);
    for (int i = 0; i < 10; i++) tick();
    RX_VALID = 1'b0;
    tick();
    chk("level_count", FIFO_COUNT, 1);
    serve("level");

    // IACK outside I_REQ is ignored
    INTC_IACK = 1'b1;
    tick();
    INTC_IACK = 1'b0;
    tick();
    chk("stray_iack_key", KEY_BUFFER, 8'h29);
    chk("stray_iack_irq", INTC_IRQ, 0);

    // Overflow: nine events into an eight-entry FIFO, no service
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i));
      if (i <= 8) expect_event(1'b0, 1'b0, 8'(i));
    end
    chk("ovf_count", FIFO_COUNT, 8);
    chk("ovf_flag", OVERFLOW, 1);
    for (int i = 1; i <= 8; i++) serve($sformatf("ovf_drain%0d", i));
    chk("ovf_drain_count", FIFO_COUNT, 0);
    chk("ovf_sticky", OVERFLOW, 1);
    OVF_CLR = 1'b1;
    tick();
    OVF_CLR = 1'b0;
    chk("ovf_clr", OVERFLOW, 0);

    // Push and pop in the same cycle at full
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i));
      expect_event(1'b0, 1'b0, 8'h10 + 8'(i));
    end
    chk("full_count", FIFO_COUNT, 8);
    chk("full_irq", INTC_IRQ, 1);
    INTC_IACK = 1'b1;
    RX_DATA   = 8'h18;
    RX_VALID  = 1'b1;
    expect_event(1'b0, 1'b0, 8'h18);
    tick();
    INTC_IACK = 1'b0;
    RX_VALID  = 1'b0;
    exp = sb_q.pop_front();
    chk("simul_key", KEY_BUFFER, exp[7:0]);
    chk("simul_count", FIFO_COUNT, 8);
    chk("simul_ovf", OVERFLOW, 0);
    INTC_IEND = 1'b1;
    tick();
    INTC_IEND = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) serve($sformatf("simul_drain%0d", i));

    // Reset while in service with a partial break prefix pending
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h21 + 8'(i));
      expect_event(1'b0, 1'b0, 8'h21 + 8'(i));
    end
    for (int i = 0; i < 30 && INTC_IRQ !== 1'b1; i++) tick();
    chk("rstmid_irq", INTC_IRQ, 1);
    INTC_IACK = 1'b1;
    tick();
    INTC_IACK = 1'b0;
    exp = sb_q.pop_front();
    chk("rstmid_key", KEY_BUFFER, exp[7:0]);
    chk("rstmid_count", FIFO_COUNT, 3);
    send_byte(8'hF0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rstmid_irq_after", INTC_IRQ, 0);
    chk("rstmid_count_after", FIFO_COUNT, 0);
    chk("rstmid_key_after", KEY_BUFFER, 0);
    chk("rstmid_flags_after", KEY_FLAGS, 0);
    sb_q.delete();
    tick();
    send_byte(8'h35);
    expect_event(1'b0, 1'b0, 8'h35);
    chk("post_rst_count", FIFO_COUNT, 1);
    serve("post_rst");
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
